// File: rtl/dcache_pkg.sv
// Shared types, widths and field-width helpers for the direct-mapped data cache.
package dcache_pkg;

   localparam int LINE_W = 128;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEM_WR  = 2'd1,
      MEM_RD  = 2'd2,
      RELEASE = 2'd3
   } dcache_state_e;

   function automatic int off_width();
      return $clog2(LINE_W / 8);
   endfunction

   function automatic int idx_width(input int num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int tag_width(input int addr_w, input int num_lines);
      return addr_w - $clog2(num_lines) - $clog2(LINE_W / 8);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage: combinational lookup port, synchronous line
// refill, single-word store update and single-cycle valid clear.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int IDX_W     = 5,
   parameter int TAG_W     = 3
) (
   input  logic              clk,
   input  logic              valid_clr_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic              rd_valid_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [LINE_W-1:0] rd_line_o,
   input  logic              line_we_i,
   input  logic [IDX_W-1:0]  line_idx_i,
   input  logic [TAG_W-1:0]  line_tag_i,
   input  logic [LINE_W-1:0] line_data_i,
   input  logic              word_we_i,
   input  logic [IDX_W-1:0]  word_idx_i,
   input  logic [1:0]        word_sel_i,
   input  logic [WORD_W-1:0] word_data_i
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_line_o  = data_q[rd_idx_i];

   // Clear has priority so a refill racing a reset never leaves a stale valid line.
   always_ff @(posedge clk) begin
      if (valid_clr_i) begin
         valid_q <= {NUM_LINES{1'b0}};
      end else if (line_we_i) begin
         valid_q[line_idx_i] <= 1'b1;
      end else begin
         valid_q <= valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (line_we_i) begin
         tag_q[line_idx_i]  <= line_tag_i;
         data_q[line_idx_i] <= line_data_i;
      end else if (word_we_i) begin
         data_q[word_idx_i][{word_sel_i, 5'b00000} +: WORD_W] <= word_data_i;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Defining DCACHE_STATS_EN adds 16-bit read-hit, read-miss and store counters.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int ADDR_W    = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [WORD_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_re,
   output logic [WORD_W-1:0] cpu_rdata,
   output logic              stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   output logic              mem_hit,
   output logic              mem_miss,
`ifdef DCACHE_STATS_EN
   output logic [15:0]       stat_rd_hit,
   output logic [15:0]       stat_rd_miss,
   output logic [15:0]       stat_wr,
`endif
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int IDX_W = idx_width(NUM_LINES);
   localparam int TAG_W = tag_width(ADDR_W, NUM_LINES);
   localparam int OFF_W = off_width();

   dcache_state_e     state_q;
   logic              mem_we_q;
   logic              mem_re_q;
   logic              mem_hit_q;
   logic              mem_miss_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [WORD_W-1:0] mem_wdata_q;
   logic              wr_done_q;

   logic [IDX_W-1:0]  idx_s;
   logic [TAG_W-1:0]  tag_s;
   logic [1:0]        word_s;
   logic              arr_valid_s;
   logic [TAG_W-1:0]  arr_tag_s;
   logic [LINE_W-1:0] arr_line_s;
   logic              hit_s;
   logic [WORD_W-1:0] hit_word_s;
   logic              stall_s;
   logic [WORD_W-1:0] rdata_s;
   logic              line_we_s;
   logic              word_we_s;
   logic              addr_lsb_unused_s;

   assign idx_s             = cpu_addr[IDX_W+OFF_W-1:OFF_W];
   assign tag_s             = cpu_addr[ADDR_W-1:IDX_W+OFF_W];
   assign word_s            = cpu_addr[3:2];
   assign addr_lsb_unused_s = ^cpu_addr[1:0];

   dcache_array #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_array (
      .clk         (clk),
      .valid_clr_i (reset),
      .rd_idx_i    (idx_s),
      .rd_valid_o  (arr_valid_s),
      .rd_tag_o    (arr_tag_s),
      .rd_line_o   (arr_line_s),
      .line_we_i   (line_we_s),
      .line_idx_i  (idx_s),
      .line_tag_i  (tag_s),
      .line_data_i (mem_rdata),
      .word_we_i   (word_we_s),
      .word_idx_i  (idx_s),
      .word_sel_i  (word_s),
      .word_data_i (cpu_wdata)
   );

   assign hit_s = arr_valid_s && (arr_tag_s == tag_s);

   always_comb begin
      case (word_s)
         2'd0:    hit_word_s = arr_line_s[31:0];
         2'd1:    hit_word_s = arr_line_s[63:32];
         2'd2:    hit_word_s = arr_line_s[95:64];
         2'd3:    hit_word_s = arr_line_s[127:96];
         default: hit_word_s = arr_line_s[31:0];
      endcase
   end

   // A store that just finished in memory is released through wr_done_q instead of restarting.
   always_comb begin
      stall_s = 1'b1;
      rdata_s = {WORD_W{1'b0}};
      if (state_q == IDLE) begin
         if (cpu_we) begin
            stall_s = ~wr_done_q;
         end else if (cpu_re) begin
            stall_s = ~hit_s;
            rdata_s = hit_s ? hit_word_s : {WORD_W{1'b0}};
         end else begin
            stall_s = 1'b0;
         end
      end else begin
         stall_s = 1'b1;
      end
   end

   always_comb begin
      line_we_s = 1'b0;
      word_we_s = 1'b0;
      if (!reset && mem_ready) begin
         line_we_s = (state_q == MEM_RD);
         word_we_s = (state_q == MEM_WR) && mem_hit_q;
      end else begin
         line_we_s = 1'b0;
         word_we_s = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_hit_q   <= 1'b0;
         mem_miss_q  <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {WORD_W{1'b0}};
         wr_done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               wr_done_q <= 1'b0;
               if (cpu_we && !wr_done_q) begin
                  state_q     <= MEM_WR;
                  mem_we_q    <= 1'b1;
                  mem_hit_q   <= hit_s;
                  mem_miss_q  <= ~hit_s;
                  mem_addr_q  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                  mem_wdata_q <= cpu_wdata;
               end else if (cpu_re && !cpu_we && !hit_s) begin
                  state_q    <= MEM_RD;
                  mem_re_q   <= 1'b1;
                  mem_hit_q  <= 1'b0;
                  mem_miss_q <= 1'b1;
                  mem_addr_q <= {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               end else begin
                  state_q <= IDLE;
               end
            end
            MEM_WR, MEM_RD: begin
               if (mem_ready) begin
                  state_q     <= RELEASE;
                  mem_we_q    <= 1'b0;
                  mem_re_q    <= 1'b0;
                  mem_hit_q   <= 1'b0;
                  mem_miss_q  <= 1'b0;
                  mem_addr_q  <= {ADDR_W{1'b0}};
                  mem_wdata_q <= {WORD_W{1'b0}};
                  wr_done_q   <= (state_q == MEM_WR);
               end else begin
                  state_q <= state_q;
               end
            end
            RELEASE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q     <= IDLE;
               mem_we_q    <= 1'b0;
               mem_re_q    <= 1'b0;
               mem_hit_q   <= 1'b0;
               mem_miss_q  <= 1'b0;
               mem_addr_q  <= {ADDR_W{1'b0}};
               mem_wdata_q <= {WORD_W{1'b0}};
               wr_done_q   <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_rdata = rdata_s;
   assign stall     = stall_s;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign mem_hit   = mem_hit_q;
   assign mem_miss  = mem_miss_q;

`ifdef DCACHE_STATS_EN
   logic [15:0] rd_hit_q, rd_hit_d;
   logic [15:0] rd_miss_q, rd_miss_d;
   logic [15:0] wr_q, wr_d;
   logic        rd_fill_q;

   // The re-evaluated hit that completes a refill is already counted as a miss.
   always_comb begin
      rd_hit_d  = rd_hit_q;
      rd_miss_d = rd_miss_q;
      wr_d      = wr_q;
      if (state_q == IDLE && cpu_re && !cpu_we && hit_s && !rd_fill_q) begin
         rd_hit_d = rd_hit_q + 16'd1;
      end else begin
         rd_hit_d = rd_hit_q;
      end
      if (state_q == MEM_RD && mem_ready) begin
         rd_miss_d = rd_miss_q + 16'd1;
      end else begin
         rd_miss_d = rd_miss_q;
      end
      if (state_q == MEM_WR && mem_ready) begin
         wr_d = wr_q + 16'd1;
      end else begin
         wr_d = wr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_hit_q  <= 16'd0;
         rd_miss_q <= 16'd0;
         wr_q      <= 16'd0;
         rd_fill_q <= 1'b0;
      end else begin
         rd_hit_q  <= rd_hit_d;
         rd_miss_q <= rd_miss_d;
         wr_q      <= wr_d;
         if (state_q == MEM_RD && mem_ready) begin
            rd_fill_q <= 1'b1;
         end else if (state_q == IDLE) begin
            rd_fill_q <= 1'b0;
         end else begin
            rd_fill_q <= rd_fill_q;
         end
      end
   end

   assign stat_rd_hit  = rd_hit_q;
   assign stat_rd_miss = rd_miss_q;
   assign stat_wr      = wr_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a fixed-latency DataMem model.
module tb_dcache_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic [11:0]  cpu_addr;
   logic [31:0]  cpu_wdata;
   logic         cpu_we;
   logic         cpu_re;
   logic [31:0]  cpu_rdata;
   logic         stall;
   logic [11:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic         mem_we;
   logic         mem_re;
   logic         mem_hit;
   logic         mem_miss;
   logic [127:0] mem_rdata = 128'd0;
   logic         mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [15:0]  stat_rd_hit;
   logic [15:0]  stat_rd_miss;
   logic [15:0]  stat_wr;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] mem [1024];
   int          lat_cnt = 0;

   int          st_cnt;
   logic [31:0] rd_v;
   logic        s_re, s_we, s_hit, s_miss, s_both;
   logic [11:0] s_addr;
   logic [31:0] s_wdata;

   dcache_ctrl #(.NUM_LINES(32), .ADDR_W(12)) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_we       (cpu_we),
      .cpu_re       (cpu_re),
      .cpu_rdata    (cpu_rdata),
      .stall        (stall),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_re       (mem_re),
      .mem_hit      (mem_hit),
      .mem_miss     (mem_miss),
`ifdef DCACHE_STATS_EN
      .stat_rd_hit  (stat_rd_hit),
      .stat_rd_miss (stat_rd_miss),
      .stat_wr      (stat_wr),
`endif
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready)
   );

   always #5 clk = ~clk;

   // DataMem model: ready pulses in the fifth cycle of a held request.
   always @(negedge clk) begin
      if (mem_ready) begin
         mem_ready = 1'b0;
         lat_cnt   = 0;
      end else if (mem_re || mem_we) begin
         lat_cnt = lat_cnt + 1;
         if (lat_cnt == 5) begin
            mem_ready = 1'b1;
            if (mem_we) begin
               mem[mem_addr[11:2]] = mem_wdata;
            end else begin
               mem_rdata = {mem[{mem_addr[11:4], 2'd3}], mem[{mem_addr[11:4], 2'd2}],
                            mem[{mem_addr[11:4], 2'd1}], mem[{mem_addr[11:4], 2'd0}]};
            end
         end
      end else begin
         lat_cnt = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge; holds the request until stall drops.
   task automatic access(input logic we, input logic re, input logic [11:0] addr,
                         input logic [31:0] wd);
      cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wd;
      st_cnt = 0; rd_v = 32'd0;
      s_re = 1'b0; s_we = 1'b0; s_hit = 1'b0; s_miss = 1'b0; s_both = 1'b0;
      s_addr = 12'd0; s_wdata = 32'd0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mem_re || mem_we) begin
            s_addr  = mem_addr;
            s_wdata = mem_wdata;
         end
         s_re   = s_re   | mem_re;
         s_we   = s_we   | mem_we;
         s_hit  = s_hit  | mem_hit;
         s_miss = s_miss | mem_miss;
         s_both = s_both | (mem_re & mem_we);
         if (!stall) break;
         st_cnt = st_cnt + 1;
      end
      rd_v = cpu_rdata;
      @(posedge clk); #1;
      cpu_we = 1'b0; cpu_re = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
      reset = 1'b1; cpu_addr = 12'd0; cpu_wdata = 32'd0; cpu_we = 1'b0; cpu_re = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_stall",    {31'd0, stall},    32'd0);
      check("rst_rdata",    cpu_rdata,         32'd0);
      check("rst_mem_re",   {31'd0, mem_re},   32'd0);
      check("rst_mem_we",   {31'd0, mem_we},   32'd0);
      check("rst_mem_hit",  {31'd0, mem_hit},  32'd0);
      check("rst_mem_miss", {31'd0, mem_miss}, 32'd0);
      check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
      @(posedge clk); #1;

      access(1'b0, 1'b1, 12'h040, 32'd0);
      check("cold_stalls", 32'(st_cnt),        32'd7);
      check("cold_re",     {31'd0, s_re},      32'd1);
      check("cold_we",     {31'd0, s_we},      32'd0);
      check("cold_miss",   {31'd0, s_miss},    32'd1);
      check("cold_addr",   {20'd0, s_addr},    32'h040);
      check("cold_data",   rd_v,               32'hA500_0010);

      access(1'b0, 1'b1, 12'h044, 32'd0);
      check("hit_stalls",  32'(st_cnt),        32'd0);
      check("hit_noreq",   {31'd0, s_re | s_we}, 32'd0);
      check("hit_data",    rd_v,               32'hA500_0011);

      access(1'b1, 1'b0, 12'h100, 32'h0000_0007);
      check("stm_stalls",  32'(st_cnt),        32'd7);
      check("stm_we",      {31'd0, s_we},      32'd1);
      check("stm_re",      {31'd0, s_re},      32'd0);
      check("stm_miss",    {31'd0, s_miss},    32'd1);
      check("stm_hit",     {31'd0, s_hit},     32'd0);
      check("stm_addr",    {20'd0, s_addr},    32'h100);
      check("stm_wdata",   s_wdata,            32'h0000_0007);
      access(1'b0, 1'b1, 12'h100, 32'd0);
      check("stm_rd_stalls", 32'(st_cnt),      32'd7);
      check("stm_rd_re",   {31'd0, s_re},      32'd1);
      check("stm_rd_data", rd_v,               32'h0000_0007);

      access(1'b1, 1'b0, 12'h048, 32'hDEAD_BEEF);
      check("sth_stalls",  32'(st_cnt),        32'd7);
      check("sth_hit",     {31'd0, s_hit},     32'd1);
      check("sth_miss",    {31'd0, s_miss},    32'd0);
      check("sth_addr",    {20'd0, s_addr},    32'h048);
      check("sth_wdata",   s_wdata,            32'hDEAD_BEEF);
      access(1'b0, 1'b1, 12'h048, 32'd0);
      check("sth_rd_stalls", 32'(st_cnt),      32'd0);
      check("sth_rd_data", rd_v,               32'hDEAD_BEEF);

      access(1'b0, 1'b1, 12'h240, 32'd0);
      check("cfl_stalls",  32'(st_cnt),        32'd7);
      check("cfl_addr",    {20'd0, s_addr},    32'h240);
      check("cfl_data",    rd_v,               32'hA500_0090);
      access(1'b0, 1'b1, 12'h040, 32'd0);
      check("cfl_back_stalls", 32'(st_cnt),    32'd7);
      check("cfl_back_data", rd_v,             32'hA500_0010);
      access(1'b0, 1'b1, 12'h048, 32'd0);
      check("cfl_wt_stalls", 32'(st_cnt),      32'd0);
      check("cfl_wt_data", rd_v,               32'hDEAD_BEEF);

      access(1'b1, 1'b1, 12'h080, 32'h1234_5678);
      check("pri_we",      {31'd0, s_we},      32'd1);
      check("pri_re",      {31'd0, s_re},      32'd0);
      check("pri_both",    {31'd0, s_both},    32'd0);
      check("pri_stalls",  32'(st_cnt),        32'd7);
      check("pri_rdata",   rd_v,               32'd0);
      check("pri_addr",    {20'd0, s_addr},    32'h080);

      cpu_addr = 12'h1C0; cpu_re = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_re",      {31'd0, mem_re},    32'd1);
      check("mid_addr",    {20'd0, mem_addr},  32'h1C0);
      @(posedge clk); #1;
      reset = 1'b1; cpu_re = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_re",    {31'd0, mem_re},   32'd0);
      check("mid_rst_we",    {31'd0, mem_we},   32'd0);
      check("mid_rst_miss",  {31'd0, mem_miss}, 32'd0);
      check("mid_rst_stall", {31'd0, stall},    32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      access(1'b0, 1'b1, 12'h040, 32'd0);
      check("post_rst_stalls", 32'(st_cnt),    32'd7);
      check("post_rst_re",   {31'd0, s_re},    32'd1);
      check("post_rst_data", rd_v,             32'hA500_0010);
`ifdef DCACHE_STATS_EN
      check("stat_rd_miss", {16'd0, stat_rd_miss}, 32'd1);
      check("stat_rd_hit",  {16'd0, stat_rd_hit},  32'd0);
      check("stat_wr",      {16'd0, stat_wr},      32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller that sits between the single-cycle core's load/store port and `DataMem`. It serves read hits with zero wait states and forwards every store to memory. It refills 128-bit lines on read misses. While a memory transaction is outstanding it stalls the core.

## Interface
Parameters:
- `NUM_LINES`, 32: number of cache lines; must be a power of two. Index width `IDX_W` = log2(`NUM_LINES`).
- `ADDR_W`, 12: byte address width, matching `DataMem`. Tag width is `ADDR_W`-`IDX_W`-4.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `cpu_addr` in `ADDR_W`: byte address; bits [1:0] are ignored.
- `cpu_wdata` in 32: store data.
- `cpu_we` in 1: store request.
- `cpu_re` in 1: load request.
- `cpu_rdata` out 32: load data, valid when `cpu_re` is high and `stall` is low.
- `stall` out 1: the core must hold its request and PC.
- `mem_addr` out `ADDR_W`: block-aligned for refill, word-aligned for store.
- `mem_wdata` out 32: store data forwarded to memory.
- `mem_we` / `mem_re` out 1: memory write and read requests.
- `mem_hit` / `mem_miss` out 1: lookup result qualifying the memory request.
- `mem_rdata` in 128: refill line.
- `mem_ready` in 1: one-cycle completion pulse from memory.

## Operation
- Lookup fields:
  - index = `cpu_addr`[`IDX_W`+3:4].
  - word = `cpu_addr`[3:2].
  - hit = valid[index] and tag[index] equals the address tag.
- Line layout: word k of the line is data[32k+31:32k]. Byte 0 of the line sits at data[7:0].
- States:
  - IDLE: evaluates the request.
  - MEM_WR: store in progress.
  - MEM_RD: refill in progress.
  - RELEASE: one cycle with all memory requests low, so `DataMem` can drop `ready`.
- IDLE transitions:
  - No request: stay in IDLE, `stall`=0.
  - Read hit: `cpu_rdata` = line word, driven combinationally; `stall`=0; stay in IDLE.
  - Read miss: `stall`=1, go to MEM_RD.
  - Any store: `stall`=1, go to MEM_WR. The hit/miss result is latched.
- MEM_WR:
  - Drive `mem_we`=1, `mem_addr`={`cpu_addr`[11:2],2'b00}, `mem_wdata`=`cpu_wdata`.
  - Drive `mem_hit`/`mem_miss` from the latched lookup result.
  - On `mem_ready`: if the store hit, write `cpu_wdata` into the cached word; go to RELEASE.
  - A store miss does not allocate a line.
- MEM_RD:
  - Drive `mem_re`=1, `mem_miss`=1, `mem_addr`={tag,index,4'b0000}.
  - On `mem_ready`: write `mem_rdata` into the line, set the tag, set valid; go to RELEASE.
- RELEASE: `stall`=1, all memory outputs 0. Next state is IDLE, where the held request is re-evaluated; a refilled read then hits.
- If `cpu_we` and `cpu_re` are both high, the store wins and the read is ignored. `mem_we` and `mem_re` are never high together.
- The controller waits indefinitely for `mem_ready`. There is no timeout.

## Timing
- Reset value of every output is 0, except `stall`, which follows its combinational rule.
- Reset clears all valid bits in one cycle and forces IDLE.
- Reset during MEM_RD or MEM_WR: the line is left unchanged, requests are dropped the next cycle, and the state returns to IDLE.
- Read hit: zero wait; `cpu_rdata` is valid in the same cycle.
- Memory transactions with `DataMem` (`mem_ready` visible in cycle 5 after entering MEM_RD/MEM_WR):
  - Stall cycles 0–6 (7 cycles).
  - The request completes in cycle 7.
- `mem_rdata` is sampled only on the `mem_ready` edge.
- `stall` is a Mealy output: it rises in the cycle the miss or store is detected.

## Configuration
- `DCACHE_STATS_EN` defined adds three outputs, `stat_rd_hit`, `stat_rd_miss` and `stat_wr`, each 16 bits.
  - Each counter increments once per completed access and wraps at 16'hFFFF.
  - All three clear on `reset`.
- Without the macro, these ports and their counters do not exist.

## Structure
- `dcache_pkg` holds:
  - the state enum (IDLE, MEM_WR, MEM_RD, RELEASE);
  - `LINE_W`=128 and `WORD_W`=32;
  - tag/index/offset width functions derived from `ADDR_W` and `NUM_LINES`.
- Sub-module `dcache_array` holds the tag, valid and data storage:
  - combinational read port;
  - synchronous ports for a full-line write and a single-word write;
  - synchronous clear of the valid bits.
- `dcache_ctrl` holds only the FSM and the address/field logic.

## Test plan
- Cold read: reset, read 0x040 → `mem_re`=1, `mem_miss`=1, `mem_addr`=0x040. `stall` is high for 7 cycles, then the read returns the memory word at 0x040.
- Read hit: re-read 0x044 after that refill → `stall`=0, correct data in the same cycle, no memory request.
- Store miss then read: write 0x0000_0007 to 0x100 → `mem_we`=1, `mem_miss`=1, no allocation. A subsequent read of 0x100 misses, refills, and returns 7.
- Store hit: after refilling 0x040, write 0xDEAD_BEEF to 0x048 → `mem_hit`=1. A read of 0x048 then hits with 0xDEAD_BEEF, without a refill.
- Conflict and priority:
  - Read 0x040 then 0x240 (same index, different tag) → the second read refills.
  - `cpu_we`=`cpu_re`=1 → only `mem_we` is asserted.
- Reset mid-refill: assert `reset` in cycle 2 of MEM_RD → the next cycle is IDLE with memory requests low, and read 0x040 misses.
